// File: rtl/vending_pkg.sv
// Shared types and constants for the change dispenser.
// Coin codes order the denominations from largest to smallest.
package vending_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        SELECT,
        REQ,
        RELEASE,
        DONE,
        ERR
    } state_e;

    localparam logic [1:0] SEL_10 = 2'd0;
    localparam logic [1:0] SEL_5  = 2'd1;
    localparam logic [1:0] SEL_2  = 2'd2;
    localparam logic [1:0] SEL_1  = 2'd3;

    localparam logic [7:0] VAL_10 = 8'd10;
    localparam logic [7:0] VAL_5  = 8'd5;
    localparam logic [7:0] VAL_2  = 8'd2;
    localparam logic [7:0] VAL_1  = 8'd1;

    function automatic logic [1:0] greedy_sel(input logic [7:0] amt);
        logic [1:0] sel;
        if (amt >= VAL_10)     sel = SEL_10;
        else if (amt >= VAL_5) sel = SEL_5;
        else if (amt >= VAL_2) sel = SEL_2;
        else                   sel = SEL_1;
        return sel;
    endfunction

    function automatic logic [7:0] coin_value(input logic [1:0] sel);
        logic [7:0] val;
        unique case (sel)
            SEL_10:  val = VAL_10;
            SEL_5:   val = VAL_5;
            SEL_2:   val = VAL_2;
            default: val = VAL_1;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/ack_timer.sv
// Counts cycles spent waiting for coin_ack; expired flags the
// cycle on which the count would reach LIMIT.
module ack_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != W'(LIMIT))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired = enable && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser driving a coin ejector over a
// four-phase req/ack handshake; every output is a register.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] price,
    input  logic [7:0] paid,
    input  logic       coin_ack,
    output logic       coin_req,
    output logic [1:0] coin_sel,
    output logic [7:0] change_left,
    output logic       busy,
    output logic       done,
    output logic       short_err,
    output logic       timeout_err
);

    state_e     state_q, state_d;
    logic [7:0] price_q, price_d;
    logic [7:0] paid_q, paid_d;
    logic [7:0] change_q, change_d;
    logic [1:0] sel_q, sel_d;
    logic       req_q, req_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       short_q, short_d;
    logic       tmo_q, tmo_d;
    logic       tmr_clear;
    logic       tmr_en;
    logic       tmr_expired;

    ack_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    // Outputs are computed for the state being entered, so they
    // appear in the same cycle as that state.
    always_comb begin
        state_d   = state_q;
        price_d   = price_q;
        paid_d    = paid_q;
        change_d  = change_q;
        sel_d     = sel_q;
        req_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        short_d   = 1'b0;
        tmo_d     = 1'b0;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    price_d  = price;
                    paid_d   = paid;
                    busy_d   = 1'b1;
                    short_d  = (paid < price);
                    change_d = (paid < price) ? 8'd0 : paid - price;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (paid_q < price_q) begin
                    state_d = ERR;
                end else begin
                    change_d = paid_q - price_q;
                    state_d  = SELECT;
                end
            end
            SELECT: begin
                tmr_clear = 1'b1;
                if (change_q == 8'd0) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    sel_d   = greedy_sel(change_q);
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                tmr_en = 1'b1;
                req_d  = 1'b1;
                if (coin_ack) begin
                    req_d    = 1'b0;
                    change_d = change_q - coin_value(sel_q);
                    state_d  = RELEASE;
                end else if (tmr_expired) begin
                    req_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = ERR;
                end
            end
            RELEASE: begin
                if (!coin_ack) state_d = SELECT;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            ERR: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            price_q  <= '0;
            paid_q   <= '0;
            change_q <= '0;
            sel_q    <= SEL_10;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            short_q  <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            price_q  <= price_d;
            paid_q   <= paid_d;
            change_q <= change_d;
            sel_q    <= sel_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            short_q  <= short_d;
            tmo_q    <= tmo_d;
        end
    end

    assign coin_req    = req_q;
    assign coin_sel    = sel_q;
    assign change_left = change_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign short_err   = short_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a coin-count
// reference model; ACK_TIMEOUT is shortened to 8 cycles.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] price;
    logic [7:0] paid;
    logic       coin_ack;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic [7:0] change_left;
    logic       busy;
    logic       done;
    logic       short_err;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    change_dispenser #(.ACK_TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .price       (price),
        .paid        (paid),
        .coin_ack    (coin_ack),
        .coin_req    (coin_req),
        .coin_sel    (coin_sel),
        .change_left (change_left),
        .busy        (busy),
        .done        (done),
        .short_err   (short_err),
        .timeout_err (timeout_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish before 2ms");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; coin_ack = 1'b0;
        price = 8'd0; paid = 8'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({coin_req, coin_sel, change_left, busy, done, short_err, timeout_err} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b sel=%0d left=%0d busy=%b done=%b short=%b tmo=%b want all 0",
                     coin_req, coin_sel, change_left, busy, done, short_err, timeout_err);
        end
        reset = 1'b0;
        coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || coin_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b req=%b want 0 0", busy, coin_req);
        end
    endtask

    // dly < 0 picks a random ack delay; noise adds ignored start/ack pulses.
    task automatic run_txn(input logic [7:0] pr, input logic [7:0] pd,
                           input int dly, input bit noise, input string name);
        logic [1:0] q[$];
        logic [7:0] rem;
        int c, d, h;
        int vals[4] = '{10, 5, 2, 1};
        q.delete();
        if (noise) begin
            coin_ack = 1'b1;
            @(negedge clk);
            coin_ack = 1'b0;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s idle_ack: got busy=%b want 0", name, busy);
            end
        end
        price = pr; paid = pd; start = 1'b1;
        @(negedge clk);
        if (noise) begin
            price = ~pr; paid = ~pd;
        end else begin
            start = 1'b0;
        end
        checks++;
        if (busy !== 1'b1 || short_err !== (pd < pr) || coin_req !== 1'b0) begin
            errors++;
            $display("FAIL %s calc: got busy=%b short=%b req=%b want 1 %b 0",
                     name, busy, short_err, coin_req, (pd < pr));
        end
        @(negedge clk);
        start = 1'b0;
        if (pd < pr) begin
            checks++;
            if (busy !== 1'b1 || short_err !== 1'b0 || coin_req !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s err_state: got busy=%b short=%b req=%b done=%b want 1 0 0 0",
                         name, busy, short_err, coin_req, done);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s err_exit: got busy=%b want 0", name, busy);
            end
            return;
        end
        c = int'(pd) - int'(pr);
        rem = 8'(c);
        repeat (c / 10) q.push_back(2'd0);
        repeat ((c % 10) / 5) q.push_back(2'd1);
        repeat ((c % 5) / 2) q.push_back(2'd2);
        repeat ((c % 5) % 2) q.push_back(2'd3);
        checks++;
        if (change_left !== rem || coin_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s select0: got left=%0d req=%b busy=%b want %0d 0 1",
                     name, change_left, coin_req, busy, rem);
        end
        if (noise) begin
            start = 1'b1; coin_ack = 1'b1;
        end
        foreach (q[i]) begin
            @(negedge clk);
            start = 1'b0;
            d = (dly < 0) ? int'($urandom_range(0, 5)) : dly;
            coin_ack = (d == 0);
            checks++;
            if (coin_req !== 1'b1 || coin_sel !== q[i] || change_left !== rem) begin
                errors++;
                $display("FAIL %s coin%0d_req: got req=%b sel=%0d left=%0d want 1 %0d %0d",
                         name, i, coin_req, coin_sel, change_left, q[i], rem);
            end
            for (int k = 1; k <= d; k++) begin
                @(negedge clk);
                if (k == d) coin_ack = 1'b1;
                checks++;
                if (coin_req !== 1'b1 || coin_sel !== q[i]) begin
                    errors++;
                    $display("FAIL %s coin%0d_hold: got req=%b sel=%0d want 1 %0d",
                             name, i, coin_req, coin_sel, q[i]);
                end
            end
            @(negedge clk);
            rem = rem - 8'(vals[q[i]]);
            checks++;
            if (coin_req !== 1'b0 || change_left !== rem) begin
                errors++;
                $display("FAIL %s coin%0d_release: got req=%b left=%0d want 0 %0d",
                         name, i, coin_req, change_left, rem);
            end
            h = int'($urandom_range(0, 3));
            for (int k = 0; k < h; k++) begin
                @(negedge clk);
                checks++;
                if (coin_req !== 1'b0) begin
                    errors++;
                    $display("FAIL %s coin%0d_ack_high: got req=%b want 0", name, i, coin_req);
                end
            end
            coin_ack = 1'b0;
            @(negedge clk);
            checks++;
            if (coin_req !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s coin%0d_select: got req=%b done=%b want 0 0",
                         name, i, coin_req, done);
            end
            if (noise) begin
                start = 1'b1; coin_ack = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0; coin_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || change_left !== 8'd0 || coin_req !== 1'b0) begin
            errors++;
            $display("FAIL %s done: got done=%b busy=%b left=%0d req=%b want 1 1 0 0",
                     name, done, busy, change_left, coin_req);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_exit: got done=%b busy=%b want 0 0", name, done, busy);
        end
        if (noise) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s no_queue: got busy=%b want 0", name, busy);
            end
        end
    endtask

    task automatic test_single_coin();
        run_txn(8'd15, 8'd20, 2, 1'b0, "single_coin");
    endtask

    task automatic test_all_coins();
        run_txn(8'd12, 8'd30, -1, 1'b0, "all_coins");
    endtask

    task automatic test_exact();
        run_txn(8'd10, 8'd10, 0, 1'b0, "exact");
    endtask

    task automatic test_short();
        run_txn(8'd15, 8'd5, 0, 1'b0, "short");
    endtask

    task automatic test_timeout();
        price = 8'd0; paid = 8'd2; start = 1'b1; coin_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (coin_req !== 1'b1 || coin_sel !== 2'd2) begin
            errors++;
            $display("FAIL timeout_req: got req=%b sel=%0d want 1 2", coin_req, coin_sel);
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (coin_req !== 1'b1 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait%0d: got req=%b tmo=%b want 1 0", k, coin_req, timeout_err);
            end
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1 || coin_req !== 1'b0 || change_left !== 8'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: got tmo=%b req=%b left=%0d busy=%b want 1 0 2 1",
                     timeout_err, coin_req, change_left, busy);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b0 || change_left !== 8'd2) begin
            errors++;
            $display("FAIL timeout_exit: got tmo=%b busy=%b left=%0d want 0 0 2",
                     timeout_err, busy, change_left);
        end
    endtask

    task automatic test_reset_mid();
        price = 8'd0; paid = 8'd25; start = 1'b1; coin_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (coin_req !== 1'b1 || coin_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_req: got req=%b sel=%0d want 1 0", coin_req, coin_sel);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({coin_req, coin_sel, change_left, busy, done, short_err, timeout_err} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got req=%b sel=%0d left=%0d busy=%b want all 0",
                     coin_req, coin_sel, change_left, busy);
        end
        reset = 1'b0;
        run_txn(8'd0, 8'd25, -1, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_txn(8'd3, 8'd21, -1, 1'b1, "b2b_a");
        run_txn(8'd7, 8'd7, -1, 1'b1, "b2b_b");
        run_txn(8'd9, 8'd4, -1, 1'b1, "b2b_c");
        run_txn(8'd0, 8'd9, -1, 1'b0, "b2b_d");
    endtask

    task automatic test_random();
        logic [7:0] pr, pd;
        int diff;
        for (int n = 0; n < 40; n++) begin
            pr = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) begin
                diff = -int'($urandom_range(1, 30));
            end else begin
                diff = int'($urandom_range(0, 40));
            end
            diff = int'(pr) + diff;
            if (diff > 255) diff = 255;
            if (diff < 0) diff = 0;
            pd = 8'(diff);
            run_txn(pr, pd, -1, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_coin();
        test_all_coins();
        test_exact();
        test_short();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
